// File: rtl/dac_pkg.sv
// Shared definitions for the dac modulator and its upstream sample feeder.
package dac_pkg;
  localparam int DAC_WIDTH = 8;
  localparam int DAC_FRAME = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } feed_state_e;
endpackage

// File: rtl/dac_sync_fifo.sv
// Single-clock FIFO with show-ahead head; full/empty derive from the occupancy count.
module dac_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop cancel out in the count.
    if (do_push && !do_pop) level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/dac_sample_feeder.sv
// Paces buffered samples onto dac_in, one per PERIOD clocks, with a conv strobe and sticky underrun.
module dac_sample_feeder
  import dac_pkg::*;
#(
  parameter int WIDTH  = DAC_WIDTH,
  parameter int DEPTH  = 16,
  parameter int PERIOD = DAC_FRAME,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] dac_in,
  output logic             conv,
  output logic             underrun,
  output logic [LW-1:0]    level
);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  feed_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic             conv_q, conv_d;
  logic             und_q, und_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, tick;
  logic [WIDTH-1:0] fifo_head;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && !fifo_full;
  assign tick      = (state_q == RUN) && (cnt_q == LAST);
  // Emptiness is the pre-push state, so a sample arriving on a tick waits for the next slot.
  assign fifo_pop  = tick && !fifo_empty;

  dac_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;
    conv_d  = 1'b0;
    und_d   = und_q;

    // A tick is served even if enable drops in the same cycle.
    if (fifo_pop) begin
      dac_d  = fifo_head;
      conv_d = 1'b1;
    end
    if (tick && fifo_empty) und_d = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = PRIME;
          und_d   = 1'b0;
        end
      end
      PRIME: begin
        cnt_d = '0;
        if (!enable) state_d = IDLE;
        else if (!fifo_empty || fifo_push) begin
          // Preload so the first RUN cycle is a tick.
          state_d = RUN;
          cnt_d   = LAST;
        end
      end
      RUN: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dac_q   <= '0;
      conv_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dac_q   <= dac_d;
      conv_q  <= conv_d;
      und_q   <= und_d;
    end
  end

  assign dac_in   = dac_q;
  assign conv     = conv_q;
  assign underrun = und_q;
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Randomized scoreboard bench for dac_sample_feeder against a slot-time reference model.
module tb_dac_sample_feeder;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int P  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  dac_in;
  logic          conv;
  logic          underrun;
  logic [LW-1:0] level;

  dac_sample_feeder #(.WIDTH(W), .DEPTH(D), .PERIOD(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .dac_in   (dac_in),
    .conv     (conv),
    .underrun (underrun),
    .level    (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a sample queue, a run mode and the absolute cycle of the next slot.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_d[$];
  int           exp_c[$];
  int           mode = 0;   // 0 stopped, 1 waiting for data, 2 running
  int           next_slot = 0;
  int           sz;
  logic         m_und = 1'b0;
  logic [W-1:0] m_dac = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); exp_d.delete(); exp_c.delete();
      mode = 0; m_und = 1'b0; m_dac = '0;
    end else begin
      sz = mq.size();
      if (mode == 2 && cyc == next_slot) begin
        next_slot = next_slot + P;
        if (sz > 0) begin
          m_dac = mq.pop_front();
          exp_d.push_back(m_dac);
          exp_c.push_back(cyc + 1);
        end else m_und = 1'b1;
      end
      if (s_valid && sz < D) mq.push_back(s_data);
      if (!enable) mode = 0;
      else if (mode == 0) begin
        mode = 1; m_und = 1'b0;
      end else if (mode == 1 && (sz > 0 || s_valid)) begin
        mode = 2; next_slot = cyc + 1;
      end
    end
    cyc++;
  end

  // Monitor: pops an expected delivery whenever conv is seen, flags missing or extra strobes.
  always @(negedge clk) begin
    chk("level", 32'(level), 32'(mq.size()));
    chk("s_ready", 32'(s_ready), 32'(mq.size() < D));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("dac_in", 32'(dac_in), 32'(m_dac));
    if (conv === 1'b1) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL spurious_conv cyc=%0d got=conv want=no conv", cyc);
      end else begin
        chk("conv_data", 32'(dac_in), 32'(exp_d.pop_front()));
        chk("conv_cycle", 32'(cyc), 32'(exp_c.pop_front()));
      end
    end else if (exp_c.size() > 0 && exp_c[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_conv cyc=%0d got=no conv want=%0h", cyc, exp_d[0]);
      void'(exp_d.pop_front());
      void'(exp_c.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic push1(input logic [W-1:0] v);
    s_valid = 1'b1; s_data = v;
    step();
    s_valid = 1'b0;
  endtask

  logic [W-1:0] seq [3];

  initial begin
    // Reset and idle buffering
    do_reset();
    for (int i = 0; i < 3; i++) push1(W'($urandom));
    step(3);
    chk("idle_level", 32'(level), 32'd3);
    chk("idle_dac", 32'(dac_in), 32'd0);

    // Basic pacing
    do_reset();
    enable = 1'b1;
    step();
    seq[0] = 8'hE6; seq[1] = 8'h10; seq[2] = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = seq[i];
      step();
    end
    s_valid = 1'b0;
    step(14);
    chk("pace_level", 32'(level), 32'd0);
    chk("pace_last", 32'(dac_in), 32'h7F);

    // Underrun
    do_reset();
    push1(8'h55);
    enable = 1'b1;
    step(10);
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_hold", 32'(dac_in), 32'h55);
    push1(8'h66);
    step(6);
    chk("ur_new", 32'(dac_in), 32'h66);
    chk("ur_sticky", 32'(underrun), 32'd1);

    // Full FIFO, then drain with s_valid held
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = W'($urandom);
      step();
    end
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(s_ready), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = W'($urandom);
      step();
    end
    s_valid = 1'b0;

    // Enable toggle mid-period, re-enable, then reset while running
    step(2);
    enable = 1'b0;
    step(6);
    enable = 1'b1;
    step(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_conv", 32'(conv), 32'd0);
    chk("rst_dac", 32'(dac_in), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_und", 32'(underrun), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // Randomized segments with varying producer rate, enable drops and occasional reset
    for (int seg = 0; seg < 60; seg++) begin
      int rate;
      rate = $urandom_range(0, 100);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
        s_valid = ($urandom_range(0, 99) < rate);
        s_data  = W'($urandom);
        if ($urandom_range(0, 49) == 0) enable = ~enable;
        step();
        rst = 1'b0;
      end
    end

    s_valid = 1'b0;
    enable = 1'b1;
    step(4 * P * D + 8);
    chk("drain_pending", 32'(exp_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Upstream pacing stage for the `dac` modulator. Accepts 8-bit samples from a producer over a valid/ready handshake, buffers them in a small FIFO, and presents one sample per fixed sample period on `dac_in` with a one-cycle `conv` strobe. The sample period matches the modulator frame length, so `dac` always converts a stable value for a whole frame. Holds the last value and flags a sticky underrun when the producer falls behind.

## Interface
- `WIDTH`, 8: sample width; must equal the `dac_in` width of `dac`.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `PERIOD`, 256: clocks per sample; ≥ 2. Default equals one 8-bit modulator frame.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run/stop for sample pacing. Level-sensitive.
- `s_data`  in  WIDTH  sample from producer.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  FIFO can accept; equals `!full`.
- `dac_in`  out  WIDTH  sample to `dac`; registered.
- `conv`  out  1  one-cycle strobe: `dac_in` updated this cycle.
- `underrun`  out  1  sticky; a sample slot found the FIFO empty.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- Reset values: `dac_in`=0, `conv`=0, `underrun`=0, `level`=0, `s_ready`=1. FIFO is emptied, state is IDLE, period counter is 0.
- Push: occurs when `s_valid && s_ready`. No push while full, even if a pop happens in the same cycle.
- Pop: only on a slot tick with `level`≠0, where emptiness is evaluated before any same-cycle push. A simultaneous push and pop leaves `level` unchanged.
- FSM states:
  - IDLE: counter held at 0, no ticks. Goes to PRIME when `enable`=1.
  - PRIME: waits for `level`≥1. Goes to RUN with the counter preloaded to PERIOD-1, so the first tick falls in the first RUN cycle.
  - RUN: counter counts 0..PERIOD-1 and wraps. A tick occurs when counter==PERIOD-1.
  - From any state, `enable`=0 returns to IDLE next cycle. FIFO contents and `dac_in` are retained; `conv` is forced to 0.
- Tick with FIFO non-empty: pop head, then `dac_in`←head and `conv`=1 on the next cycle.
- Tick with FIFO empty: `dac_in` is held, `conv` stays 0, and `underrun` is set. Stay in RUN; the counter keeps wrapping, so later slots stay aligned to the frame.
- Clearing `underrun`: only by `rst`, or by an `enable` 0→1 transition (cleared on entry to PRIME).
- Pointers: log2(DEPTH)-bit read and write pointers wrap naturally. Full and empty come from `level`, never from pointer compare alone.

## Timing
- Sample latency, idle FIFO: a push accepted in cycle t while in PRIME reaches RUN at t+1. The tick is at t+1, and `dac_in`/`conv` update at t+2.
- In RUN, consecutive `conv` pulses are exactly PERIOD cycles apart while there is no underrun.
- `conv` is high for exactly one cycle per delivered sample, and `dac_in` is stable between pulses.
- `s_ready` is combinational from `level` only (no path from `s_valid`). It changes the cycle after a push or pop.
- Reset mid-RUN: on the next cycle, all outputs are at their reset values and any buffered samples are lost.
- `enable` dropping on a tick cycle: the tick is still served (pop and `conv` next cycle), then the block goes to IDLE.

## Structure
- Shared package `dac_pkg` holds:
  - the FSM state typedef (IDLE, PRIME, RUN);
  - the `DAC_WIDTH`=8 constant, shared with `dac`;
  - the `DAC_FRAME`=256 constant.
- One sub-module, `dac_sync_fifo` (parameters WIDTH and DEPTH). Its interface is push/pop/data/level, with show-ahead read of the head.
- The top level holds the FSM, period counter, output registers and the underrun flag.

## Test plan
- Reset and idle: assert `rst` for 2 cycles with `enable`=0, then push 3 samples. Required: `level`=3, `conv` never asserted, `dac_in`=0.
- Basic pacing (PERIOD=4): enable, then push 0xE6, 0x10 and 0x7F back to back. Required: `conv` pulses 4 cycles apart, `dac_in` sequence E6→10→7F, `level` returns to 0.
- Underrun (PERIOD=4): push one sample 0x55 and enable. Required: `dac_in`=0x55 with `conv`; the next slot gives no `conv`, `dac_in` stays 0x55 and `underrun`=1. A later push of 0x66 is delivered on a slot boundary and `underrun` stays 1.
- Full FIFO (DEPTH=4): push with `enable`=0 and `s_valid` held high. Required: exactly 4 accepted, `s_ready`=0, `level`=4. Enable with `s_valid` still high: each pop frees one entry and exactly one further push is accepted the cycle after.
- Enable toggle and reset mid-RUN: deassert `enable` in the middle of a period. Required: `conv` stays 0 and `dac_in` is held. Re-enable: `underrun` is cleared and the first `conv` comes 2 cycles after entering PRIME with data. Assert `rst` during RUN: all outputs reach reset values next cycle and `level`=0.
